// File: rtl/srio_nwr_target.sv
// SRIO NWRITE/NWRITE_R target: strips the header, forwards the payload, checks length, and optionally responds.
// Define SRIO_TGT_RESP_EN to emit a response beat after NWRITE_R packets.
module srio_nwr_target #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             log_clk,
  input  logic             log_rst,
  input  logic             treq_tvalid_in,
  output logic             treq_tready_o,
  input  logic             treq_tlast_in,
  input  logic [63:0]      treq_tdata_in,
  input  logic [7:0]       treq_tkeep_in,
  input  logic [31:0]      treq_tuser_in,
  output logic             tresp_tvalid_o,
  output logic             tresp_tlast_o,
  output logic [63:0]      tresp_tdata_o,
  output logic [7:0]       tresp_tkeep_o,
  output logic [31:0]      tresp_tuser_o,
  input  logic             tresp_tready_in,
  output logic             user_tvalid_o,
  output logic             user_tfirst_o,
  output logic             user_tlast_o,
  output logic [63:0]      user_tdata_o,
  output logic [7:0]       user_tkeep_o,
  input  logic             user_tready_in,
  output logic [33:0]      user_addr_o,
  output logic [15:0]      user_tsize_o,
  output logic [15:0]      user_src_id_o,
  output logic             len_err_o,
  output logic             unsup_o,
  output logic [CNT_W-1:0] pkt_cnt_o,
  output logic [CNT_W-1:0] err_cnt_o
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_DATA = 2'd1;
  localparam logic [1:0] S_DROP = 2'd2;
  localparam logic [1:0] S_RESP = 2'd3;

  logic [1:0]  state;
  logic [15:0] dest_id_r;
  logic [7:0]  tid_r;
  logic [1:0]  prio_r;
  logic        crf_r;
  logic        nwr_r_r;
  logic [4:0]  size_hi_r;
  logic        first_r;
  logic [5:0]  beat_cnt;

  logic       in_data;
  logic       treq_hs;
  logic [3:0] hdr_ftype;
  logic [3:0] hdr_ttype;
  logic       hdr_supported;
  logic [5:0] exp_beats;
  logic [5:0] rcv_beats;
  logic       goto_resp;

  assign hdr_ftype     = treq_tdata_in[55:52];
  assign hdr_ttype     = treq_tdata_in[51:48];
  assign hdr_supported = (hdr_ftype == 4'h5) && ((hdr_ttype == 4'h4) || (hdr_ttype == 4'h5));
  assign exp_beats     = {1'b0, size_hi_r} + 6'd1;
  assign rcv_beats     = beat_cnt + 6'd1;
  assign in_data       = (state == S_DATA);

  // Ready is forced low during reset even though state already reads IDLE.
  always_comb begin
    treq_tready_o = 1'b0;
    if (!log_rst) begin
      case (state)
        S_IDLE:  treq_tready_o = 1'b1;
        S_DATA:  treq_tready_o = user_tready_in;
        S_DROP:  treq_tready_o = 1'b1;
        default: treq_tready_o = 1'b0;
      endcase
    end
  end

  assign treq_hs       = treq_tvalid_in && treq_tready_o;
  assign user_tvalid_o = in_data && treq_tvalid_in;
  assign user_tfirst_o = user_tvalid_o && first_r;
  assign user_tlast_o  = user_tvalid_o && treq_tlast_in;
  assign user_tdata_o  = in_data ? treq_tdata_in : '0;
  assign user_tkeep_o  = in_data ? treq_tkeep_in : '0;

`ifdef SRIO_TGT_RESP_EN
  localparam logic RESP_EN = 1'b1;
  logic [1:0] resp_prio;
  assign resp_prio      = (prio_r == 2'd3) ? 2'd3 : prio_r + 2'd1;
  assign tresp_tvalid_o = (state == S_RESP);
  assign tresp_tlast_o  = tresp_tvalid_o;
  assign tresp_tdata_o  = {tid_r, 4'hD, 4'h0, 1'b0, resp_prio, crf_r, 44'h0};
  assign tresp_tkeep_o  = 8'hFF;
  assign tresp_tuser_o  = {dest_id_r, user_src_id_o};
  logic unused_bits;
  assign unused_bits = &{1'b0, treq_tdata_in[47], treq_tdata_in[35:34]};
`else
  localparam logic RESP_EN = 1'b0;
  assign tresp_tvalid_o = 1'b0;
  assign tresp_tlast_o  = 1'b0;
  assign tresp_tdata_o  = '0;
  assign tresp_tkeep_o  = '0;
  assign tresp_tuser_o  = '0;
  logic unused_bits;
  assign unused_bits = &{1'b0, treq_tdata_in[47], treq_tdata_in[35:34],
                         dest_id_r, tid_r, prio_r, crf_r, nwr_r_r};
`endif

  assign goto_resp = RESP_EN && nwr_r_r;

  always_ff @(posedge log_clk or posedge log_rst) begin
    if (log_rst) begin
      state         <= S_IDLE;
      user_addr_o   <= '0;
      user_tsize_o  <= '0;
      user_src_id_o <= '0;
      dest_id_r     <= '0;
      tid_r         <= '0;
      prio_r        <= '0;
      crf_r         <= 1'b0;
      nwr_r_r       <= 1'b0;
      size_hi_r     <= '0;
      first_r       <= 1'b0;
      beat_cnt      <= '0;
      len_err_o     <= 1'b0;
      unsup_o       <= 1'b0;
      pkt_cnt_o     <= '0;
      err_cnt_o     <= '0;
    end else begin
      len_err_o <= 1'b0;
      unsup_o   <= 1'b0;
      case (state)
        S_IDLE: if (treq_hs) begin
          if (!hdr_supported) begin
            unsup_o   <= 1'b1;
            err_cnt_o <= err_cnt_o + CNT_W'(1);
            if (!treq_tlast_in) state <= S_DROP;
          end else if (treq_tlast_in) begin
            len_err_o <= 1'b1;
            err_cnt_o <= err_cnt_o + CNT_W'(1);
          end else begin
            user_addr_o   <= treq_tdata_in[33:0];
            user_tsize_o  <= {8'h00, treq_tdata_in[43:36]} + 16'd1;
            user_src_id_o <= treq_tuser_in[31:16];
            dest_id_r     <= treq_tuser_in[15:0];
            tid_r         <= treq_tdata_in[63:56];
            prio_r        <= treq_tdata_in[46:45];
            crf_r         <= treq_tdata_in[44];
            nwr_r_r       <= (hdr_ttype == 4'h5);
            size_hi_r     <= treq_tdata_in[43:39];
            first_r       <= 1'b1;
            beat_cnt      <= '0;
            state         <= S_DATA;
          end
        end
        S_DATA: if (treq_hs) begin
          first_r  <= 1'b0;
          beat_cnt <= rcv_beats;
          if (treq_tlast_in) begin
            pkt_cnt_o <= pkt_cnt_o + CNT_W'(1);
            if (rcv_beats != exp_beats) begin
              len_err_o <= 1'b1;
              err_cnt_o <= err_cnt_o + CNT_W'(1);
            end
            state <= goto_resp ? S_RESP : S_IDLE;
          end
        end
        S_DROP: if (treq_hs && treq_tlast_in) state <= S_IDLE;
        S_RESP: if (tresp_tready_in) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_srio_nwr_target.sv
// Directed self-checking bench for srio_nwr_target; response checks follow SRIO_TGT_RESP_EN.
module tb_srio_nwr_target;

  logic        log_clk = 1'b0;
  logic        log_rst;
  logic        treq_tvalid_in, treq_tready_o, treq_tlast_in;
  logic [63:0] treq_tdata_in;
  logic [7:0]  treq_tkeep_in;
  logic [31:0] treq_tuser_in;
  logic        tresp_tvalid_o, tresp_tlast_o, tresp_tready_in;
  logic [63:0] tresp_tdata_o;
  logic [7:0]  tresp_tkeep_o;
  logic [31:0] tresp_tuser_o;
  logic        user_tvalid_o, user_tfirst_o, user_tlast_o, user_tready_in;
  logic [63:0] user_tdata_o;
  logic [7:0]  user_tkeep_o;
  logic [33:0] user_addr_o;
  logic [15:0] user_tsize_o, user_src_id_o;
  logic        len_err_o, unsup_o;
  logic [15:0] pkt_cnt_o, err_cnt_o;

  int errors = 0;
  int checks = 0;

  srio_nwr_target #(.CNT_W(16)) dut (
    .log_clk(log_clk), .log_rst(log_rst),
    .treq_tvalid_in(treq_tvalid_in), .treq_tready_o(treq_tready_o), .treq_tlast_in(treq_tlast_in),
    .treq_tdata_in(treq_tdata_in), .treq_tkeep_in(treq_tkeep_in), .treq_tuser_in(treq_tuser_in),
    .tresp_tvalid_o(tresp_tvalid_o), .tresp_tlast_o(tresp_tlast_o), .tresp_tdata_o(tresp_tdata_o),
    .tresp_tkeep_o(tresp_tkeep_o), .tresp_tuser_o(tresp_tuser_o), .tresp_tready_in(tresp_tready_in),
    .user_tvalid_o(user_tvalid_o), .user_tfirst_o(user_tfirst_o), .user_tlast_o(user_tlast_o),
    .user_tdata_o(user_tdata_o), .user_tkeep_o(user_tkeep_o), .user_tready_in(user_tready_in),
    .user_addr_o(user_addr_o), .user_tsize_o(user_tsize_o), .user_src_id_o(user_src_id_o),
    .len_err_o(len_err_o), .unsup_o(unsup_o), .pkt_cnt_o(pkt_cnt_o), .err_cnt_o(err_cnt_o)
  );

  always #5 log_clk = ~log_clk;

  // Running tallies of observed traffic; tests compare deltas.
  int          ubeats = 0, ufirst_cnt = 0, ufirst_pos = -1, ulast_cnt = 0, ulast_pos = -1;
  int          uvalid_cyc = 0, len_err_cnt = 0, unsup_cnt = 0, resp_cnt = 0, resp_vcyc = 0;
  logic [63:0] ud [256];
  logic [63:0] resp_data = '0;
  logic [31:0] resp_user = '0;
  logic [7:0]  resp_keep = '0;
  logic        resp_last = 1'b0;

  always @(posedge log_clk) begin
    if (!log_rst) begin
      if (user_tvalid_o && user_tready_in) begin
        if (user_tfirst_o) begin ufirst_cnt++; ufirst_pos = ubeats; end
        if (user_tlast_o) begin ulast_cnt++; ulast_pos = ubeats; end
        ud[ubeats % 256] = user_tdata_o;
        ubeats++;
      end
      if (user_tvalid_o) uvalid_cyc++;
      if (len_err_o) len_err_cnt++;
      if (unsup_o) unsup_cnt++;
      if (tresp_tvalid_o) resp_vcyc++;
      if (tresp_tvalid_o && tresp_tready_in) begin
        resp_cnt++;
        resp_data = tresp_tdata_o;
        resp_user = tresp_tuser_o;
        resp_keep = tresp_tkeep_o;
        resp_last = tresp_tlast_o;
      end
    end
  end

  function automatic logic [63:0] hdr(input logic [7:0] tid, input logic [3:0] ft, input logic [3:0] tt,
                                      input logic [1:0] pr, input logic crf, input logic [7:0] sz,
                                      input logic [33:0] ad);
    return {tid, ft, tt, 1'b0, pr, crf, sz, 2'b00, ad};
  endfunction

  task automatic idle(input int n);
    repeat (n) @(posedge log_clk);
    #1;
  endtask

  task automatic drive_beat(input logic [63:0] d, input logic last, input logic [31:0] u, output int waits);
    logic rdy;
    logic done;
    treq_tvalid_in = 1'b1;
    treq_tdata_in  = d;
    treq_tkeep_in  = 8'hFF;
    treq_tlast_in  = last;
    treq_tuser_in  = u;
    waits = 0;
    done  = 1'b0;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge log_clk);
      rdy = treq_tready_o;
      @(posedge log_clk);
      #1;
      if (rdy) done = 1'b1;
      else waits++;
    end
    if (!done) begin
      errors++; checks++;
      $display("FAIL handshake_timeout: beat %h not accepted within 200 cycles", d);
    end
  endtask

  task automatic send_pkt(input logic [63:0] h, input logic [31:0] u, input int n,
                          input logic [63:0] base, output int total_waits);
    int w;
    total_waits = 0;
    drive_beat(h, n == 0, u, w);
    total_waits += w;
    for (int i = 0; i < n; i++) begin
      drive_beat(base + 64'(i), i == n - 1, u, w);
      total_waits += w;
    end
    treq_tvalid_in = 1'b0;
    treq_tlast_in  = 1'b0;
  endtask

  task automatic test_reset();
    log_rst = 1'b1;
    treq_tvalid_in = 1'b1; treq_tlast_in = 1'b0; treq_tdata_in = '0;
    treq_tkeep_in = '0; treq_tuser_in = '0;
    user_tready_in = 1'b1; tresp_tready_in = 1'b1;
    repeat (3) @(posedge log_clk);
    @(negedge log_clk);
    checks++; if (treq_tready_o !== 1'b0) begin errors++; $display("FAIL rst_tready: got %b want 0", treq_tready_o); end
    checks++; if ({user_tvalid_o, user_tfirst_o, user_tlast_o, tresp_tvalid_o, tresp_tlast_o, len_err_o, unsup_o} !== 7'b0) begin
      errors++; $display("FAIL rst_flags: got %b want 0", {user_tvalid_o, user_tfirst_o, user_tlast_o, tresp_tvalid_o, tresp_tlast_o, len_err_o, unsup_o}); end
    checks++; if ({pkt_cnt_o, err_cnt_o} !== 32'h0) begin errors++; $display("FAIL rst_cnt: got %h/%h want 0/0", pkt_cnt_o, err_cnt_o); end
    @(posedge log_clk); #1;
    treq_tvalid_in = 1'b0;
    log_rst = 1'b0;
    @(negedge log_clk);
    checks++; if (treq_tready_o !== 1'b1) begin errors++; $display("FAIL rst_release_tready: got %b want 1", treq_tready_o); end
    idle(1);
  endtask

  task automatic test_nwrite();
    int b0, f0, l0, le0, un0, rv0, w, bad;
    b0 = ubeats; f0 = ufirst_cnt; l0 = ulast_cnt; le0 = len_err_cnt; un0 = unsup_cnt; rv0 = resp_vcyc;
    send_pkt(hdr(8'h11, 4'h5, 4'h4, 2'd0, 1'b0, 8'h3F, 34'h3ff00ff00), 32'h000100F0, 8, 64'hA000_0000_0000_0000, w);
    checks++; if (user_tsize_o !== 16'd64) begin errors++; $display("FAIL nw_tsize: got %0d want 64", user_tsize_o); end
    checks++; if (user_addr_o !== 34'h3ff00ff00) begin errors++; $display("FAIL nw_addr: got %h want 3ff00ff00", user_addr_o); end
    checks++; if (user_src_id_o !== 16'h0001) begin errors++; $display("FAIL nw_src: got %h want 0001", user_src_id_o); end
    idle(3);
    checks++; if (ubeats - b0 !== 8) begin errors++; $display("FAIL nw_beats: got %0d want 8", ubeats - b0); end
    checks++; if (ufirst_cnt - f0 !== 1 || ufirst_pos !== b0) begin errors++; $display("FAIL nw_first: count %0d pos %0d want 1 at %0d", ufirst_cnt - f0, ufirst_pos, b0); end
    checks++; if (ulast_cnt - l0 !== 1 || ulast_pos !== b0 + 7) begin errors++; $display("FAIL nw_last: count %0d pos %0d want 1 at %0d", ulast_cnt - l0, ulast_pos, b0 + 7); end
    bad = 0;
    for (int i = 0; i < 8; i++) if (ud[(b0 + i) % 256] !== 64'hA000_0000_0000_0000 + 64'(i)) bad++;
    checks++; if (bad !== 0) begin errors++; $display("FAIL nw_data: %0d wrong beats want 0", bad); end
    checks++; if (pkt_cnt_o !== 16'd1 || err_cnt_o !== 16'd0) begin errors++; $display("FAIL nw_cnt: got %0d/%0d want 1/0", pkt_cnt_o, err_cnt_o); end
    checks++; if (len_err_cnt - le0 !== 0 || unsup_cnt - un0 !== 0 || resp_vcyc - rv0 !== 0) begin
      errors++; $display("FAIL nw_noerr: len %0d unsup %0d resp %0d want 0/0/0", len_err_cnt - le0, unsup_cnt - un0, resp_vcyc - rv0); end
  endtask

  task automatic test_nwrite_r();
    int b0, r0, rv0, w;
    b0 = ubeats; r0 = resp_cnt; rv0 = resp_vcyc;
    send_pkt(hdr(8'h5A, 4'h5, 4'h5, 2'd1, 1'b0, 8'h07, 34'h000001000), 32'h000100F0, 1, 64'hB000_0000_0000_0000, w);
    idle(4);
    checks++; if (ubeats - b0 !== 1) begin errors++; $display("FAIL nwr_beats: got %0d want 1", ubeats - b0); end
    checks++; if (pkt_cnt_o !== 16'd2 || err_cnt_o !== 16'd0) begin errors++; $display("FAIL nwr_cnt: got %0d/%0d want 2/0", pkt_cnt_o, err_cnt_o); end
`ifdef SRIO_TGT_RESP_EN
    checks++; if (resp_cnt - r0 !== 1 || resp_vcyc - rv0 !== 1) begin errors++; $display("FAIL nwr_resp_count: got %0d beats %0d cycles want 1/1", resp_cnt - r0, resp_vcyc - rv0); end
    checks++; if (resp_data !== 64'h5AD0_4000_0000_0000) begin errors++; $display("FAIL nwr_resp_data: got %h want 5ad0400000000000", resp_data); end
    checks++; if (resp_user !== 32'h00F00001) begin errors++; $display("FAIL nwr_resp_user: got %h want 00f00001", resp_user); end
    checks++; if (resp_keep !== 8'hFF || resp_last !== 1'b1) begin errors++; $display("FAIL nwr_resp_keep_last: got %h/%b want ff/1", resp_keep, resp_last); end
`else
    checks++; if (resp_vcyc - rv0 !== 0 || resp_cnt - r0 !== 0) begin errors++; $display("FAIL nwr_no_resp: got %0d cycles want 0", resp_vcyc - rv0); end
    checks++; if ({tresp_tdata_o, tresp_tkeep_o, tresp_tuser_o, tresp_tlast_o} !== '0) begin errors++; $display("FAIL nwr_resp_tied: got %h want 0", tresp_tdata_o); end
`endif
  endtask

  task automatic test_len_err();
    int b0, le0, un0, w;
    b0 = ubeats; le0 = len_err_cnt; un0 = unsup_cnt;
    send_pkt(hdr(8'h22, 4'h5, 4'h4, 2'd0, 1'b0, 8'h0F, 34'h000002000), 32'h00020003, 3, 64'hC000_0000_0000_0000, w);
    idle(3);
    checks++; if (ubeats - b0 !== 3) begin errors++; $display("FAIL len_beats: got %0d want 3", ubeats - b0); end
    checks++; if (len_err_cnt - le0 !== 1) begin errors++; $display("FAIL len_pulse: got %0d want 1", len_err_cnt - le0); end
    checks++; if (err_cnt_o !== 16'd1 || pkt_cnt_o !== 16'd3) begin errors++; $display("FAIL len_cnt: err %0d pkt %0d want 1/3", err_cnt_o, pkt_cnt_o); end
    checks++; if (unsup_cnt - un0 !== 0) begin errors++; $display("FAIL len_unsup: got %0d want 0", unsup_cnt - un0); end
  endtask

  task automatic test_unsup();
    int uv0, le0, un0, w;
    uv0 = uvalid_cyc; le0 = len_err_cnt; un0 = unsup_cnt;
    send_pkt(hdr(8'h33, 4'h2, 4'h4, 2'd0, 1'b0, 8'h1F, 34'h000003000), 32'h00040005, 3, 64'hD000_0000_0000_0000, w);
    checks++; if (w !== 0) begin errors++; $display("FAIL unsup_ready: %0d stall cycles want 0", w); end
    idle(3);
    checks++; if (uvalid_cyc - uv0 !== 0) begin errors++; $display("FAIL unsup_uvalid: got %0d cycles want 0", uvalid_cyc - uv0); end
    checks++; if (unsup_cnt - un0 !== 1 || len_err_cnt - le0 !== 0) begin errors++; $display("FAIL unsup_pulse: unsup %0d len %0d want 1/0", unsup_cnt - un0, len_err_cnt - le0); end
    checks++; if (err_cnt_o !== 16'd2 || pkt_cnt_o !== 16'd3) begin errors++; $display("FAIL unsup_cnt: err %0d pkt %0d want 2/3", err_cnt_o, pkt_cnt_o); end
    @(negedge log_clk);
    checks++; if (treq_tready_o !== 1'b1) begin errors++; $display("FAIL unsup_idle: tready %b want 1", treq_tready_o); end
    idle(1);
  endtask

  task automatic test_back_to_back_stall();
    int b0, r0, rv0, w, bad, stall_bad;
    logic [31:0] u;
    u = 32'h12345678;
    b0 = ubeats; r0 = resp_cnt; rv0 = resp_vcyc;
    drive_beat(hdr(8'hC3, 4'h5, 4'h5, 2'd3, 1'b1, 8'h1F, 34'h000004000), 1'b0, u, w);
    drive_beat(64'hE000_0000_0000_0000, 1'b0, u, w);
    drive_beat(64'hE000_0000_0000_0001, 1'b0, u, w);
    user_tready_in = 1'b0;
    treq_tvalid_in = 1'b1; treq_tdata_in = 64'hE000_0000_0000_0002; treq_tlast_in = 1'b0;
    stall_bad = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge log_clk);
      if (treq_tready_o !== 1'b0 || user_tvalid_o !== 1'b1) stall_bad++;
      @(posedge log_clk); #1;
    end
    checks++; if (stall_bad !== 0) begin errors++; $display("FAIL stall_ready: %0d bad cycles want 0", stall_bad); end
    checks++; if (ubeats - b0 !== 2) begin errors++; $display("FAIL stall_hold: got %0d beats want 2", ubeats - b0); end
    user_tready_in = 1'b1;
    drive_beat(64'hE000_0000_0000_0002, 1'b0, u, w);
`ifdef SRIO_TGT_RESP_EN
    tresp_tready_in = 1'b0;
`endif
    drive_beat(64'hE000_0000_0000_0003, 1'b1, u, w);
    treq_tvalid_in = 1'b0; treq_tlast_in = 1'b0;
`ifdef SRIO_TGT_RESP_EN
    stall_bad = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge log_clk);
      if (tresp_tvalid_o !== 1'b1 || tresp_tdata_o !== 64'hC3D0_7000_0000_0000 ||
          tresp_tuser_o !== 32'h56781234 || treq_tready_o !== 1'b0) stall_bad++;
      @(posedge log_clk); #1;
    end
    tresp_tready_in = 1'b1;
    idle(3);
    checks++; if (stall_bad !== 0) begin errors++; $display("FAIL resp_hold: %0d bad cycles want 0", stall_bad); end
    checks++; if (resp_cnt - r0 !== 1 || resp_vcyc - rv0 !== 4) begin errors++; $display("FAIL resp_stall_count: got %0d beats %0d cycles want 1/4", resp_cnt - r0, resp_vcyc - rv0); end
    checks++; if (resp_data !== 64'hC3D0_7000_0000_0000 || resp_user !== 32'h56781234) begin errors++; $display("FAIL resp_stall_data: got %h/%h want c3d0700000000000/56781234", resp_data, resp_user); end
`else
    idle(3);
    checks++; if (resp_vcyc - rv0 !== 0) begin errors++; $display("FAIL stall_no_resp: got %0d cycles want 0", resp_vcyc - rv0); end
`endif
    bad = 0;
    for (int i = 0; i < 4; i++) if (ud[(b0 + i) % 256] !== 64'hE000_0000_0000_0000 + 64'(i)) bad++;
    checks++; if (ubeats - b0 !== 4 || bad !== 0) begin errors++; $display("FAIL stall_data: %0d beats %0d wrong want 4/0", ubeats - b0, bad); end
    checks++; if (pkt_cnt_o !== 16'd4 || err_cnt_o !== 16'd2) begin errors++; $display("FAIL stall_cnt: pkt %0d err %0d want 4/2", pkt_cnt_o, err_cnt_o); end
  endtask

  task automatic test_reset_mid();
    int b0, f0, le0, w;
    drive_beat(hdr(8'h44, 4'h5, 4'h4, 2'd0, 1'b0, 8'h3F, 34'h0000F0000), 1'b0, 32'h00070008, w);
    for (int i = 0; i < 3; i++) drive_beat(64'hF000_0000_0000_0000 + 64'(i), 1'b0, 32'h00070008, w);
    treq_tvalid_in = 1'b1; treq_tdata_in = 64'hF000_0000_0000_0003; treq_tlast_in = 1'b0;
    log_rst = 1'b1;
    #1;
    checks++; if ({treq_tready_o, user_tvalid_o, user_tfirst_o, user_tlast_o, tresp_tvalid_o, len_err_o, unsup_o} !== 7'b0) begin
      errors++; $display("FAIL midrst_flags: got %b want 0", {treq_tready_o, user_tvalid_o, user_tfirst_o, user_tlast_o, tresp_tvalid_o, len_err_o, unsup_o}); end
    checks++; if ({user_addr_o, user_tsize_o, user_src_id_o, user_tdata_o} !== '0) begin
      errors++; $display("FAIL midrst_latched: addr %h tsize %h src %h want 0", user_addr_o, user_tsize_o, user_src_id_o); end
    checks++; if (pkt_cnt_o !== 16'd0 || err_cnt_o !== 16'd0) begin errors++; $display("FAIL midrst_cnt: got %0d/%0d want 0/0", pkt_cnt_o, err_cnt_o); end
    repeat (2) @(posedge log_clk);
    #1;
    treq_tvalid_in = 1'b0;
    log_rst = 1'b0;
    idle(1);
    b0 = ubeats; f0 = ufirst_cnt; le0 = len_err_cnt;
    send_pkt(hdr(8'h45, 4'h5, 4'h4, 2'd0, 1'b0, 8'h3F, 34'h000010000), 32'h00070008, 8, 64'h9000_0000_0000_0000, w);
    idle(3);
    checks++; if (pkt_cnt_o !== 16'd1 || err_cnt_o !== 16'd0) begin errors++; $display("FAIL postrst_cnt: got %0d/%0d want 1/0", pkt_cnt_o, err_cnt_o); end
    checks++; if (ubeats - b0 !== 8 || ufirst_cnt - f0 !== 1 || len_err_cnt - le0 !== 0) begin
      errors++; $display("FAIL postrst_pkt: beats %0d first %0d len %0d want 8/1/0", ubeats - b0, ufirst_cnt - f0, len_err_cnt - le0); end
  endtask

  initial begin
    test_reset();
    test_nwrite();
    test_nwrite_r();
    test_len_err();
    test_unsup();
    test_back_to_back_stall();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/srio_nwr_target.md
SRIO_NWR_TARGET -- requirements
Module: srio_nwr_target

Interface
REQ-001 SHALL have parameter CNT_W, default 16, width of the packet and error counters.
REQ-002 SHALL have port log_clk, input, 1, the single clock; all logic is on its rising edge.
REQ-003 SHALL have port log_rst, input, 1, reset, asynchronous and active-high.
REQ-004 SHALL have port treq_tvalid_in, input, 1, target request beat valid (HELLO format).
REQ-005 SHALL have port treq_tready_o, output, 1, target request ready.
REQ-006 SHALL have port treq_tlast_in, input, 1, last request beat.
REQ-007 SHALL have port treq_tdata_in, input, 64, request header or payload.
REQ-008 SHALL have port treq_tkeep_in, input, 8, request byte enables.
REQ-009 SHALL have port treq_tuser_in, input, 32, {src_id[31:16], dest_id[15:0]}.
REQ-010 SHALL have ports tresp_tvalid_o/tlast_o (output, 1), tresp_tdata_o (output, 64), tresp_tkeep_o (output, 8), tresp_tuser_o (output, 32), and tresp_tready_in (input, 1), forming the response channel.
REQ-011 SHALL have ports user_tvalid_o/tfirst_o/tlast_o (output, 1), user_tdata_o (output, 64), user_tkeep_o (output, 8), and user_tready_in (input, 1), forming the payload out channel.
REQ-012 SHALL have port user_addr_o, output, 34, destination address latched from the header.
REQ-013 SHALL have port user_tsize_o, output, 16, payload bytes, equal to SIZE+1.
REQ-014 SHALL have port user_src_id_o, output, 16, requester ID.
REQ-015 SHALL have ports len_err_o and unsup_o, output, 1, one-cycle error pulses.
REQ-016 SHALL have ports pkt_cnt_o and err_cnt_o, output, CNT_W, wrapping counters.

Function
REQ-017 SHALL decode header beat fields: TID[63:56], FTYPE[55:52], TTYPE[51:48], PRIO[46:45], CRF[44], SIZE[43:36], ADDR[33:0].
REQ-018 SHALL implement the states IDLE, DATA, DROP, and RESP.
REQ-019 SHALL, in IDLE, hold treq_tready_o=1 and consume one header beat per handshake; the header is never forwarded.
REQ-020 SHALL treat a header with FTYPE=5 and TTYPE=4 (NWRITE) or TTYPE=5 (NWRITE_R) as supported, latch addr, size, src_id, TID, PRIO, and CRF, and move to DATA.
REQ-021 SHALL treat any other FTYPE/TTYPE as unsupported: pulse unsup_o, increment err_cnt_o, and move to DROP (or stay in IDLE if the header beat has tlast).
REQ-022 SHALL treat a supported header carrying tlast as a length error: pulse len_err_o, increment err_cnt_o, stay in IDLE, and issue no response.
REQ-023 SHALL, in DATA, connect the payload combinationally with zero latency: user_tvalid_o=treq_tvalid_in, treq_tready_o=user_tready_in, and tdata/tkeep/tlast passed through.
REQ-024 SHALL assert user_tfirst_o on the first payload beat only.
REQ-025 SHALL compute the expected beat count as SIZE[7:3]+1 in a 6-bit counter.
REQ-026 SHALL, on the tlast handshake, pulse len_err_o and increment err_cnt_o if the received beat count differs from expected; the packet is still forwarded in full.
REQ-027 SHALL, on the tlast handshake, increment pkt_cnt_o and go to RESP if the packet is NWRITE_R (see Configuration), otherwise to IDLE.
REQ-028 SHALL, in DROP, hold treq_tready_o=1, keep user_tvalid_o=0, and return to IDLE on the tlast handshake.
REQ-029 SHALL, in RESP, hold treq_tready_o=0 and present one registered beat: tdata={TID, 4'hD, 4'h0, 1'b0, min(PRIO+1,3), CRF, 44'h0}, tkeep=8'hFF, tlast=1, tuser={latched dest_id, latched src_id}.
REQ-030 SHALL hold the response stable until tresp_tready_in=1, then move to IDLE on the next cycle.
REQ-031 SHALL stall indefinitely while tresp_tready_in stays low, with no timeout.
REQ-032 SHALL drive user_addr_o, user_tsize_o, and user_src_id_o from the latched header, stable from the first DATA cycle until the next header is accepted.
REQ-033 SHALL wrap both counters modulo 2^CNT_W.
REQ-034 SHALL, when a pkt_cnt_o increment and an err_cnt_o increment occur in the same cycle, apply both.

Reset
REQ-035 SHALL, on log_rst high, immediately enter IDLE and clear every register, counters and latched header fields included.
REQ-036 SHALL hold every valid, first, last, and error output at 0 while log_rst is high.
REQ-037 SHALL hold treq_tready_o at 0 while log_rst is high.
REQ-038 SHALL, on reset during DATA or RESP, abandon the packet, count nothing, and issue no response.
REQ-039 SHALL set treq_tready_o=1 in the first cycle after log_rst falls.

Configuration
REQ-040 SHALL, with macro SRIO_TGT_RESP_EN defined, generate a response beat after every NWRITE_R packet, as in REQ-029.
REQ-041 SHALL, with SRIO_TGT_RESP_EN undefined, treat NWRITE_R as NWRITE, never assert tresp_tvalid_o, and tie tresp_tdata_o/tkeep_o/tuser_o/tlast_o to 0.

Verification
REQ-042 SHALL cover: NWRITE with ADDR=34'h3ff00ff00, SIZE=8'h3F, 8 payload beats, tuser=32'h000100F0 -> 8 user beats (first on beat 1, last on beat 8), user_tsize_o=64, pkt_cnt_o=1, no response, no errors.
REQ-043 SHALL cover (SRIO_TGT_RESP_EN defined): NWRITE_R with TID=8'h5A, PRIO=1, tuser=32'h000100F0, 1 payload beat -> one response beat with tdata[63:48]=16'h5AD0, PRIO field=2, tuser=32'h00F00001.
REQ-044 SHALL cover: SIZE=8'h0F with 3 payload beats -> 3 beats forwarded, len_err_o pulses once, err_cnt_o=1, pkt_cnt_o=1.
REQ-045 SHALL cover: FTYPE=2 header with 4 beats -> no user_tvalid_o, unsup_o pulses once, treq_tready_o=1 throughout, then back to IDLE.
REQ-046 SHALL cover: user_tready_in low for 5 cycles mid-packet, with tresp_tready_in low for 3 cycles during RESP -> treq_tready_o=0 during the stall, no beat lost or duplicated, response held stable.
REQ-047 SHALL cover: log_rst asserted on payload beat 4 of 8 -> all outputs 0 immediately; a following clean NWRITE completes with pkt_cnt_o=1.
